// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter in front of a single-ported 256x16 memory
//
// Shares one start/ready memory between the instruction-fetch port (0) and the
// load/store port (1). One transaction at a time, round-robin on ties.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   req0/1, rwn0/1           request (held until ack), 1 = read / 0 = write
//   addr0/1, wdata0/1        word address and write data per port
//   ack0/1                   one-cycle completion pulse to the winner
//   rdata0/1                 read data, valid with ack and held until the next read on that port
//   mem_start, mem_rwn       memory handshake start and direction
//   mem_address, mem_data_in memory address and write data (stable from ISSUE to next grant)
//   mem_data_out, mem_ready  memory read data and ready
//   busy                     high while a transaction is in ISSUE or WAIT
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        rwn0,
    input  logic        rwn1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        mem_start,
    output logic        mem_rwn,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last;
    logic        r_winner;
    logic        r_ack0;
    logic        r_ack1;
    logic [15:0] r_rdata0;
    logic [15:0] r_rdata1;
    logic        r_start;
    logic        r_rwn;
    logic [7:0]  r_address;
    logic [15:0] r_data_in;
    logic        r_busy;

    // A port whose ack is high this cycle is masked so a req still held
    // through its own ack is not issued a second time.
    logic w_elig0;
    logic w_elig1;
    logic w_any;
    logic w_pick1;

    assign w_elig0 = req0 & ~r_ack0;
    assign w_elig1 = req1 & ~r_ack1;
    assign w_any   = w_elig0 | w_elig1;
    // On a tie, port 1 wins only if port 0 was granted last (r_last == 0).
    assign w_pick1 = w_elig1 & (~w_elig0 | ~r_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_winner  <= 1'b0;
            r_ack0    <= 1'b0;
            r_ack1    <= 1'b0;
            r_rdata0  <= 16'd0;
            r_rdata1  <= 16'd0;
            r_start   <= 1'b0;
            r_rwn     <= 1'b1;
            r_address <= 8'd0;
            r_data_in <= 16'd0;
            r_busy    <= 1'b0;
        end else begin
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any && mem_ready) begin
                        r_winner  <= w_pick1;
                        r_last    <= w_pick1;
                        r_address <= w_pick1 ? addr1  : addr0;
                        r_rwn     <= w_pick1 ? rwn1   : rwn0;
                        r_data_in <= w_pick1 ? wdata1 : wdata0;
                        // Registered so that start is high for the ISSUE cycle only.
                        r_start   <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // The memory still shows ready here; it only drops after
                    // seeing start, so WAIT is entered unconditionally.
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (r_winner) begin
                            r_ack1 <= 1'b1;
                            if (r_rwn) begin
                                r_rdata1 <= mem_data_out;
                            end
                        end else begin
                            r_ack0 <= 1'b1;
                            if (r_rwn) begin
                                r_rdata0 <= mem_data_out;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ack0        = r_ack0;
    assign ack1        = r_ack1;
    assign rdata0      = r_rdata0;
    assign rdata1      = r_rdata1;
    assign mem_start   = r_start;
    assign mem_rwn     = r_rwn;
    assign mem_address = r_address;
    assign mem_data_in = r_data_in;
    assign busy        = r_busy;

endmodule
